memory_interconnect: RTL
========================

# memory_interconnect

Parametrised two-master, N-slave bus interconnect. It is the sequential successor of the combinational memory decoder and sits between the core's instruction-fetch and data ports and the ROM, RAM and peripherals. Requests from both masters go through round-robin arbitration. Each slave is selected by a base/mask decode table, and every transfer completes with an explicit req/ack handshake on both sides. Addresses outside every slave window, and transfers that run past an optional timeout, return an error response instead of hanging the core.

## Interface
- BYTE_AMNT, 8: bytes per data word; DATA_W = 8*BYTE_AMNT.
- ADDR_W, 64: address width.
- N_SLAVES, 3: number of slave channels, 1..16.
- SLAVE_BASE, {64'h1001_3000, 64'h0400_0000, 64'h0}: packed N_SLAVES*ADDR_W; slave i is at slice i.
- SLAVE_MASK, {~64'hFFF, ~64'h3FF_FFFF, ~64'hFF_FFFF}: packed N_SLAVES*ADDR_W.
- TIMEOUT_CYCLES, 256: ACCESS-state cycle limit; only used with BUS_TIMEOUT_EN.
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- m0_req, m1_req  in  1  master request; M0 = instruction fetch, M1 = data.
- m0_we, m1_we  in  1  write (1) / read (0).
- m0_addr, m1_addr  in  ADDR_W  byte address.
- m0_wr_data, m1_wr_data  in  DATA_W  write data.
- m0_byte_en, m1_byte_en  in  BYTE_AMNT  byte lanes.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_err, m1_err  out  1  error flag, valid only with ack.
- m0_rd_data, m1_rd_data  out  DATA_W  read data, valid only with ack.
- s_req  out  N_SLAVES  one-hot slave request.
- s_we  out  1  shared write strobe.
- s_addr  out  ADDR_W  shared local offset = addr & ~SLAVE_MASK[i].
- s_wr_data  out  DATA_W  shared write data.
- s_byte_en  out  BYTE_AMNT  shared byte lanes.
- s_rd_data  in  N_SLAVES*DATA_W  per-slave read data.
- s_ack  in  N_SLAVES  per-slave completion.

## Operation

**State machine: IDLE, ACCESS, RESP.**
- **IDLE**
  - If any m*_req is high, the arbiter grants one master.
  - The granted master's we, addr, wr_data and byte_en are registered.
  - The registered address is decoded.
  - On a hit, go to ACCESS; on a miss, go to RESP with the error flag set.
- **Decode**
  - Slave i is hit when (addr & SLAVE_MASK[i]) == SLAVE_BASE[i].
  - If windows overlap, the lowest index wins.
- **ACCESS**
  - s_req[sel] is held high; all other s_req bits are 0.
  - On s_ack[sel], s_rd_data[sel] is captured and the FSM goes to RESP with err=0.
  - s_ack bits on non-selected slaves are ignored.
- **RESP**
  - The granted master's ack is high for exactly one cycle.
  - rd_data carries the captured data; it is 0 on writes and on errors.
  - err carries the error flag.
  - Next state is IDLE.
- **Arbitration (round-robin)**
  - The priority pointer favours the master not granted last.
  - On simultaneous requests, the pointer's master wins and the pointer flips after each grant.
  - After reset, M0 has priority.
- **Master rules**
  - req, addr, we, data and byte_en are held stable from assertion through the ack cycle.
  - req is deasserted in the cycle after ack.
  - A req that is still high in IDLE starts a new transaction.
- **Slave rules**
  - s_addr, s_we, s_wr_data and s_byte_en are stable while s_req is high.
  - s_req drops the cycle after s_ack.
- **Reset**
  - Outputs after reset: all ack/err/rd_data = 0, s_req = 0, s_addr/s_wr_data/s_byte_en/s_we = 0, FSM in IDLE, pointer on M0.
  - A reset in the middle of a transfer abandons it without an ack.

## Timing
- Minimum latency, hit with a zero-wait slave (s_ack high in the first ACCESS cycle):
  - req is sampled at edge 0.
  - s_req is high in cycle 1.
  - ack is high in cycle 2.
  - IDLE in cycle 3.
- Minimum latency, decode miss: ack with err=1 in cycle 1.
- Throughput: at most one transfer every 3 cycles per interconnect, not per master.
- The losing master waits for the full current transfer plus IDLE.

## Configuration
- **BUS_TIMEOUT_EN defined**
  - A counter clears on entry to ACCESS and increments each ACCESS cycle.
  - If it reaches TIMEOUT_CYCLES without s_ack, s_req drops and the FSM goes to RESP with err=1 and rd_data=0.
  - A late s_ack from that slave is ignored.
- **BUS_TIMEOUT_EN undefined**
  - No counter exists; ACCESS waits indefinitely.
  - err is asserted only on a decode miss.

## Structure
- **Shared package / header mem_bus_pkg** holds:
  - FSM state encoding;
  - default ROM/RAM/UART base and mask constants;
  - the master index constants M_INST=0 and M_DATA=1.
- **Sub-module rr_arbiter** (2 requesters): grant one-hot, pointer update enabled on grant.
- Decode, datapath registers and FSM stay in the top module.

## Test plan
- Single read, zero-wait: M1 reads 0x0400_0010 with s_ack[1] tied high and s_rd_data[1]=0xDEAD_BEEF.
  - Expect s_req=3'b010 and s_addr=0x10 in cycle 1.
  - Expect m1_ack, err=0 and rd_data=0xDEAD_BEEF in cycle 2.
- Simultaneous requests after reset: M0 reads 0x100, M1 writes 0x1001_3004.
  - M0 is served first, then M1.
  - M1's s_addr=0x004, s_we=1, and M1's ack comes 3 cycles after M0's ack.
- Decode miss: M0 reads 0x8000_0000.
  - No s_req.
  - m0_ack=1, m0_err=1, rd_data=0 in cycle 1.
- Wait states: slave 0 acks after 5 cycles.
  - s_req is held for 5 cycles and addr/data are stable.
  - ack arrives one cycle after s_ack.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4): slave 2 never acks.
  - s_req drops after 4 cycles.
  - m1_ack with m1_err=1.
- Reset mid-ACCESS: assert reset for 1 cycle.
  - All outputs are 0 next cycle and no ack is issued.
  - A new M1 request then completes normally.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory interconnect: FSM encoding, default
// ROM/RAM/UART windows and master indices.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } bus_state_e;

  localparam logic [63:0] ROM_BASE  = 64'h0;
  localparam logic [63:0] ROM_MASK  = ~64'hFF_FFFF;
  localparam logic [63:0] RAM_BASE  = 64'h0400_0000;
  localparam logic [63:0] RAM_MASK  = ~64'h3FF_FFFF;
  localparam logic [63:0] UART_BASE = 64'h1001_3000;
  localparam logic [63:0] UART_MASK = ~64'hFFF;

  localparam int M_INST = 0;
  localparam int M_DATA = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Two-requester round-robin arbiter; combinational one-hot grant.
// Latency: grant in the same cycle as req. Pointer moves only when en is high.
// Backpressure: none; a losing requester simply keeps req high.
module rr_arbiter (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // ptr_q = 0 favours requester 0, 1 favours requester 1
  logic ptr_q;

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || !ptr_q)) begin
      gnt[0] = 1'b1;
    end else if (req[1]) begin
      gnt[1] = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else if (en && (gnt != 2'b00)) begin
      ptr_q <= gnt[0];
    end
  end

endmodule

// File: rtl/memory_interconnect.sv
// Two-master / N-slave interconnect with round-robin arbitration and base/mask decode.
// Latency: hit ack 2 cycles after grant (+ slave wait), miss ack 1 cycle after grant.
// Backpressure: one transfer in flight; losing master holds req. Option: BUS_TIMEOUT_EN.
module memory_interconnect
  import mem_bus_pkg::*;
#(
  parameter int                           BYTE_AMNT      = 8,
  parameter int                           ADDR_W         = 64,
  parameter int                           N_SLAVES       = 3,
  parameter logic [N_SLAVES*ADDR_W-1:0]   SLAVE_BASE     = {UART_BASE, RAM_BASE, ROM_BASE},
  parameter logic [N_SLAVES*ADDR_W-1:0]   SLAVE_MASK     = {UART_MASK, RAM_MASK, ROM_MASK},
  parameter int                           TIMEOUT_CYCLES = 256
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           m0_req,
  input  logic                           m1_req,
  input  logic                           m0_we,
  input  logic                           m1_we,
  input  logic [ADDR_W-1:0]              m0_addr,
  input  logic [ADDR_W-1:0]              m1_addr,
  input  logic [8*BYTE_AMNT-1:0]         m0_wr_data,
  input  logic [8*BYTE_AMNT-1:0]         m1_wr_data,
  input  logic [BYTE_AMNT-1:0]           m0_byte_en,
  input  logic [BYTE_AMNT-1:0]           m1_byte_en,
  output logic                           m0_ack,
  output logic                           m1_ack,
  output logic                           m0_err,
  output logic                           m1_err,
  output logic [8*BYTE_AMNT-1:0]         m0_rd_data,
  output logic [8*BYTE_AMNT-1:0]         m1_rd_data,
  output logic [N_SLAVES-1:0]            s_req,
  output logic                           s_we,
  output logic [ADDR_W-1:0]              s_addr,
  output logic [8*BYTE_AMNT-1:0]         s_wr_data,
  output logic [BYTE_AMNT-1:0]           s_byte_en,
  input  logic [N_SLAVES*8*BYTE_AMNT-1:0] s_rd_data,
  input  logic [N_SLAVES-1:0]            s_ack
);

  localparam int DATA_W = 8 * BYTE_AMNT;
  localparam int SEL_W  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  bus_state_e          state_q, state_d;
  logic [1:0]          arb_req, arb_gnt;
  logic                start, gnt_data, mst_q;
  logic                req_we;
  logic [ADDR_W-1:0]   req_addr;
  logic [DATA_W-1:0]   req_wdat;
  logic [BYTE_AMNT-1:0] req_be;
  logic                dec_hit;
  logic [SEL_W-1:0]    dec_sel, sel_q;
  logic [ADDR_W-1:0]   dec_off;
  logic                err_q;
  logic [DATA_W-1:0]   rdat_q;
  logic                sel_ack;
  logic [DATA_W-1:0]   sel_rdat;
  logic                tmo_hit;

  assign arb_req = {m1_req, m0_req};
  assign start   = (state_q == ST_IDLE) && (arb_gnt != 2'b00);

  rr_arbiter u_arb (
    .clock (clock),
    .reset (reset),
    .req   (arb_req),
    .en    (start),
    .gnt   (arb_gnt)
  );

  assign gnt_data = arb_gnt[M_DATA];
  assign req_we   = gnt_data ? m1_we      : m0_we;
  assign req_addr = gnt_data ? m1_addr    : m0_addr;
  assign req_wdat = gnt_data ? m1_wr_data : m0_wr_data;
  assign req_be   = gnt_data ? m1_byte_en : m0_byte_en;

  // Scan from the top so the lowest matching index wins on overlap
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    dec_off = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((req_addr & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        dec_hit = 1'b1;
        dec_sel = SEL_W'(i);
        dec_off = req_addr & ~SLAVE_MASK[i*ADDR_W +: ADDR_W];
      end
    end
  end

  assign sel_ack  = s_ack[sel_q];
  assign sel_rdat = s_rd_data[sel_q*DATA_W +: DATA_W];

`ifdef BUS_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clock) begin
    if (reset || (state_q != ST_ACCESS)) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Fires in the last allowed ACCESS cycle; an ack in the same cycle still wins
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = dec_hit ? ST_ACCESS : ST_RESP;
      ST_ACCESS: if (sel_ack || tmo_hit) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mst_q     <= 1'b0;
      sel_q     <= '0;
      err_q     <= 1'b0;
      rdat_q    <= '0;
      s_we      <= 1'b0;
      s_addr    <= '0;
      s_wr_data <= '0;
      s_byte_en <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        mst_q     <= gnt_data;
        sel_q     <= dec_sel;
        err_q     <= !dec_hit;
        rdat_q    <= '0;
        s_we      <= req_we;
        s_addr    <= dec_off;
        s_wr_data <= req_wdat;
        s_byte_en <= req_be;
      end else if (state_q == ST_ACCESS) begin
        if (sel_ack) begin
          err_q <= 1'b0;
          if (!s_we) rdat_q <= sel_rdat;
        end else if (tmo_hit) begin
          err_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    s_req = '0;
    if (state_q == ST_ACCESS) s_req[sel_q] = 1'b1;
  end

  assign m0_ack     = (state_q == ST_RESP) && (mst_q == 1'(M_INST));
  assign m1_ack     = (state_q == ST_RESP) && (mst_q == 1'(M_DATA));
  assign m0_err     = m0_ack && err_q;
  assign m1_err     = m1_ack && err_q;
  assign m0_rd_data = m0_ack ? rdat_q : '0;
  assign m1_rd_data = m1_ack ? rdat_q : '0;

endmodule
